// File: rtl/fifo_sync_status.sv
// Synchronous single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and flush.
module fifo_sync_status #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
            $error("fifo_sync_status: AF_LEVEL %0d outside 1..%0d",
                   AF_LEVEL, DEPTH);
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_chk
            $error("fifo_sync_status: AE_LEVEL %0d outside 0..%0d",
                   AE_LEVEL, DEPTH - 1);
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;

    logic              rd_ok;
    logic              wr_ok;
    logic              wr_go;
    logic              rd_go;
    logic [ADDR_W:0]   count_next;
    logic              overflow_next;
    logic              underflow_next;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts wr&rd.
    always_comb begin
        rd_ok = rd & ~empty;
        wr_ok = wr & (~full | rd_ok);
        wr_go = wr_ok & ~clr;
        rd_go = rd_ok & ~clr;
    end

    always_comb begin
        count_next     = count;
        overflow_next  = overflow;
        underflow_next = underflow;
        if (clr) begin
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (wr_ok && !rd_ok) begin
                count_next = count + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count_next = count - CNT_ONE;
            end
            if (wr && !wr_ok) begin
                overflow_next = 1'b1;
            end
            if (rd && empty) begin
                underflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else if (clr) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_go) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_go) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

    // Status flags come from count_next so they move on the same edge as count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == FULL_CNT);
            almost_empty <= (count_next <= AE_CNT);
            almost_full  <= (count_next >= AF_CNT);
            overflow     <= overflow_next;
            underflow    <= underflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem[w_ptr] <= w_data;
        end
    end

    assign r_data = mem[r_ptr];

    assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule

// File: tb/tb_fifo_sync_status.sv
// Directed and randomized checks of fifo_sync_status against a
// queue-based reference model.
module tb_fifo_sync_status;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int AE     = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              wr;
    logic [DATA_W-1:0] w_data;
    logic              rd;
    logic [DATA_W-1:0] r_data;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovf;
    logic              m_unf;

    fifo_sync_status #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .AF_LEVEL(AF),
        .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .wr(wr),
        .w_data(w_data),
        .rd(rd),
        .r_data(r_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
        if (n > 0) begin
            chk({tag, ".rdata"}, 32'(r_data), 32'(q[0]));
        end
    endtask

    task automatic model(input logic w, input logic [7:0] d,
                         input logic r, input logic c);
        bit was_full;
        bit was_empty;
        bit popped;
        bit pushed;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            popped    = r && !was_empty;
            pushed    = w && (!was_full || popped);
            if (w && !pushed) m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            if (popped) void'(q.pop_front());
            if (pushed) q.push_back(d);
        end
    endtask

    task automatic step(input string tag, input logic w,
                        input logic [7:0] d, input logic r,
                        input logic c);
        wr     = w;
        w_data = d;
        rd     = r;
        clr    = c;
        @(posedge clk);
        model(w, d, r, c);
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
        chk_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        clr    = 1'b0;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post_reset");

        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);

        step("ovf_wr", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(r_data), 32'h00);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(r_data), 32'(i));
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        step("wr_rd_empty", 1'b1, 8'h55, 1'b1, 1'b0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_head", 32'(r_data), 32'h55);
        step("rd_last", 1'b0, 8'h00, 1'b1, 1'b0);

        step("clr1", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("fill2", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("wr_rd_full", 1'b1, 8'h77, 1'b1, 1'b0);
        chk("wrrd_full_ovf", 32'(overflow), 32'd0);
        chk("wrrd_full_head", 32'(r_data), 32'h03);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) step("wrap_w1", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("wrap_r1", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("wrap_w2", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("wrap_head", 32'(r_data), 32'h40);
        step("clr_wr", 1'b1, 8'hEE, 1'b0, 1'b1);
        chk("clr_count", 32'(count), 32'd0);

        for (int i = 0; i < 8; i++) step("fill8", 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_data", 32'(r_data), 32'h3C);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
